// File: rtl/riscv_test_monitor_pkg.sv
// riscv_test_monitor_pkg: shared state encoding and default register indices for the test monitor
package riscv_test_monitor_pkg;
  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SETTLE  = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;
  localparam int DEFAULT_DONE_REG = 26;
  localparam int DEFAULT_PASS_REG = 27;
  localparam int DEFAULT_TNUM_REG = 3;
endpackage

// File: rtl/wb_reg_shadow.sv
// wb_reg_shadow: one address-matched copy of an architectural register, snooped from write-back
module wb_reg_shadow #(
  parameter int IDX = 1,
  parameter int AW  = 5,
  parameter int W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  output logic          hit,
  output logic [W-1:0]  nxt
);
  logic [W-1:0] q;
  // x0 is hardwired zero in the core, so a match on address 0 never counts
  assign hit = en && we && waddr == AW'(IDX) && waddr != '0;
  // nxt is the value this register holds after the coming edge
  assign nxt = hit ? wdata : q;
  // shadow storage, frozen by en once a verdict is reached
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: riscv-tests pass/fail monitor; define MONITOR_TIMEOUT_EN to build the watchdog
import riscv_test_monitor_pkg::*;

module riscv_test_monitor #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int DONE_REG       = DEFAULT_DONE_REG,
  parameter int PASS_REG       = DEFAULT_PASS_REG,
  parameter int TNUM_REG       = DEFAULT_TNUM_REG,
  parameter int SETTLE_CYCLES  = 10,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_waddr_i,
  input  logic [XLEN-1:0]       wb_wdata_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [XLEN-1:0]       fail_testnum_o,
  output logic [CNT_W-1:0]      cycle_count_o
);
  state_e state, state_n;
  logic live, live_n, done_hit, done_go;
  logic [XLEN-1:0] done_nxt, pass_nxt, tnum_nxt;
  logic [31:0] settle_cnt;
  logic [CNT_W-1:0] cyc_inc;
  assign live     = state == S_RUN || state == S_SETTLE;
  assign live_n   = state_n == S_RUN || state_n == S_SETTLE;
  assign done_go  = done_hit && done_nxt == XLEN'(1);
  assign cyc_inc  = &cycle_count_o ? cycle_count_o : cycle_count_o + 1'b1;
  wb_reg_shadow #(.IDX(DONE_REG), .AW(REG_ADDR_W), .W(XLEN)) u_done (
    .clk(clk), .rst(rst), .en(live), .we(wb_we_i), .waddr(wb_waddr_i), .wdata(wb_wdata_i),
    .hit(done_hit), .nxt(done_nxt)
  );
  wb_reg_shadow #(.IDX(PASS_REG), .AW(REG_ADDR_W), .W(XLEN)) u_pass (
    .clk(clk), .rst(rst), .en(live), .we(wb_we_i), .waddr(wb_waddr_i), .wdata(wb_wdata_i),
    .hit(), .nxt(pass_nxt)
  );
  wb_reg_shadow #(.IDX(TNUM_REG), .AW(REG_ADDR_W), .W(XLEN)) u_tnum (
    .clk(clk), .rst(rst), .en(live), .we(wb_we_i), .waddr(wb_waddr_i), .wdata(wb_wdata_i),
    .hit(), .nxt(tnum_nxt)
  );
  // next-state: a done write beats the watchdog; the verdict sees this cycle's pass write
  always_comb begin
    state_n = state;
    if (state == S_RUN) begin
      if (done_go) state_n = S_SETTLE;
`ifdef MONITOR_TIMEOUT_EN
      else if (cyc_inc == CNT_W'(TIMEOUT_CYCLES)) state_n = S_TIMEOUT;
`endif
    end else if (state == S_SETTLE && settle_cnt == '0)
      state_n = pass_nxt == XLEN'(1) ? S_PASS : S_FAIL;
  end
  // state, settle window and saturating cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RUN;
      settle_cnt    <= '0;
      cycle_count_o <= '0;
    end else begin
      state         <= state_n;
      settle_cnt    <= state == S_RUN ? 32'(SETTLE_CYCLES - 1) : settle_cnt - (settle_cnt != '0 ? 32'd1 : 32'd0);
      cycle_count_o <= live ? cyc_inc : cycle_count_o;
    end
  end
  // verdict outputs, latched once on entry to a terminal state
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o         <= 1'b0;
      pass_o         <= 1'b0;
      fail_o         <= 1'b0;
      fail_testnum_o <= '0;
    end else if (live && !live_n) begin
      done_o         <= 1'b1;
      pass_o         <= state_n == S_PASS;
      fail_o         <= state_n != S_PASS;
      fail_testnum_o <= tnum_nxt;
    end
  end
`ifdef MONITOR_TIMEOUT_EN
  // watchdog flag, set alongside the other verdict outputs
  always_ff @(posedge clk)
    if (rst) timeout_o <= 1'b0;
    else if (live && !live_n) timeout_o <= state_n == S_TIMEOUT;
`else
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed self-checking bench for riscv_test_monitor
module tb_riscv_test_monitor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wb_we_i = 1'b0;
  logic [4:0] wb_waddr_i = '0;
  logic [31:0] wb_wdata_i = '0;
  logic done_o, pass_o, fail_o, timeout_o;
  logic [31:0] fail_testnum_o, cycle_count_o;
  int n_chk = 0;
  int n_err = 0;

  riscv_test_monitor #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .fail_testnum_o(fail_testnum_o), .cycle_count_o(cycle_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we_i = 1'b1;
    wb_waddr_i = a;
    wb_wdata_i = d;
    @(negedge clk);
    wb_we_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"}, {done_o, pass_o, fail_o, timeout_o}, 4'b0000);
    check({tag, "_tnum"}, fail_testnum_o, 0);
    check({tag, "_cyc"}, cycle_count_o, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_idle("reset");
    wr(3, 5);
    wr(27, 1);
    wr(26, 1);
    cyc(9);
    check("pass_early", done_o, 0);
    cyc(1);
    check("pass_flags", {done_o, pass_o, fail_o, timeout_o}, 4'b1100);
    check("pass_tnum", fail_testnum_o, 5);
    check("pass_cyc", cycle_count_o, 13);
    cyc(5);
    check("pass_cyc_hold", cycle_count_o, 13);
    check("pass_sticky", {done_o, pass_o, fail_o}, 3'b110);

    do_reset();
    wr(3, 7);
    wr(27, 0);
    wr(26, 1);
    cyc(10);
    check("fail_flags", {done_o, pass_o, fail_o, timeout_o}, 4'b1010);
    check("fail_tnum", fail_testnum_o, 7);
    wr(27, 1);
    wr(3, 9);
    cyc(3);
    check("fail_sticky", {done_o, pass_o, fail_o}, 3'b101);
    check("fail_tnum_hold", fail_testnum_o, 7);

    do_reset();
    wr(26, 1);
    cyc(3);
    wr(26, 1);
    cyc(4);
    check("late_no_restart", done_o, 0);
    cyc(1);
    wr(27, 1);
    check("late_pass", {done_o, pass_o, fail_o}, 3'b110);

    do_reset();
    wr(26, 2);
    wr(0, 1);
    wb_waddr_i = 26;
    wb_wdata_i = 1;
    cyc(3);
    cyc(15);
    check("filter_done", done_o, 0);
    check("filter_cyc", cycle_count_o, 20);
    wr(26, 1);
    cyc(10);
    check("filter_then_fail", {done_o, fail_o}, 2'b11);

    do_reset();
`ifdef MONITOR_TIMEOUT_EN
    cyc(49);
    check("to_before", {done_o, timeout_o}, 2'b00);
    cyc(1);
    check("to_flags", {done_o, pass_o, fail_o, timeout_o}, 4'b1011);
    check("to_cyc", cycle_count_o, 50);
    cyc(5);
    check("to_cyc_hold", cycle_count_o, 50);
`else
    cyc(200);
    check("noto_done", {done_o, timeout_o}, 2'b00);
    check("noto_cyc", cycle_count_o, 200);
`endif

    do_reset();
    wr(3, 9);
    wr(27, 1);
    wr(26, 1);
    cyc(3);
    do_reset();
    check_idle("midrst");
    cyc(12);
    check("midrst_no_verdict", done_o, 0);
    do_reset();
    wr(26, 1);
    cyc(10);
    check("midrst_shadow_clr", {done_o, pass_o, fail_o}, 3'b101);
    check("midrst_tnum_clr", fail_testnum_o, 0);
    do_reset();
    wr(3, 5);
    wr(27, 1);
    wr(26, 1);
    cyc(10);
    check("midrst_pass", {done_o, pass_o, fail_o}, 3'b110);
    check("midrst_pass_tnum", fail_testnum_o, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable pass/fail monitor for riscv-tests (rv32ui-p-*) programs run on the open RISC-V SoC. It snoops the register-file write-back port and shadows the completion, pass and test-number registers. After completion it waits a settle window, then reports a sticky PASS or FAIL verdict, plus the failing test number. It sits beside the core inside the SoC, so the verdict is visible in simulation and on hardware (LEDs/UART) without hierarchical probing.

## Interface
Parameters:
- XLEN, 32: write-back data width.
- REG_ADDR_W, 5: register address width.
- DONE_REG, 26: register whose write of 1 signals test end.
- PASS_REG, 27: register holding 1 on pass.
- TNUM_REG, 3: register holding the current test number.
- SETTLE_CYCLES, 10: cycles between the done write and the verdict; must be ≥1.
- CNT_W, 32: cycle counter width.
- TIMEOUT_CYCLES, 100000: watchdog limit; must be < 2^CNT_W.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- wb_we_i, in, 1: register write enable from the core.
- wb_waddr_i, in, REG_ADDR_W: write address.
- wb_wdata_i, in, XLEN: write data.
- done_o, out, 1: a verdict has been reached (sticky).
- pass_o, out, 1: verdict is PASS.
- fail_o, out, 1: verdict is FAIL or TIMEOUT.
- timeout_o, out, 1: verdict is TIMEOUT.
- fail_testnum_o, out, XLEN: TNUM shadow latched at the verdict.
- cycle_count_o, out, CNT_W: cycles spent in RUN/SETTLE; saturates at all-ones.

## Operation
- FSM states: RUN, SETTLE, PASS, FAIL, TIMEOUT. Reset enters RUN.
- Shadow registers: done_sh, pass_sh, tnum_sh, all XLEN wide, reset to 0.
  - A shadow updates when wb_we_i=1 and wb_waddr_i equals its index.
  - Writes to address 0 are ignored, even if a parameter is 0.
  - Shadows keep updating in RUN and SETTLE and freeze in the terminal states.
- RUN:
  - Write of exactly 1 to DONE_REG → SETTLE, and the settle counter loads SETTLE_CYCLES-1.
  - Any other value written to DONE_REG is stored in the shadow; the FSM stays in RUN.
- SETTLE:
  - The counter decrements each cycle. At 0, the next state is PASS if pass_sh==1, else FAIL.
  - The comparison uses pass_sh as updated in that same cycle, so a write on the final settle cycle counts.
  - Further DONE_REG writes do not restart the settle window.
- Terminal states are sticky until rst. fail_testnum_o latches tnum_sh on entry and holds it.
- cycle_count_o increments in RUN and SETTLE and holds in terminal states.
- Simultaneous events:
  - A done write in the same cycle the watchdog expires → SETTLE; done wins.
  - rst asserted in any state, including mid-SETTLE, clears everything to reset values on the next edge.

## Timing
- All outputs are registered. Reset values: done_o, pass_o, fail_o and timeout_o are 0; fail_testnum_o and cycle_count_o are 0.
- Latency: a done write sampled at edge N makes done_o high after edge N+SETTLE_CYCLES.
- pass_o, fail_o and timeout_o assert in the same cycle as done_o. Exactly one of pass_o/fail_o is high when done_o=1.
- No handshake; inputs are sampled every cycle.

## Configuration
- MONITOR_TIMEOUT_EN defined:
  - The watchdog is active. When cycle_count_o reaches TIMEOUT_CYCLES in RUN, the FSM goes to TIMEOUT.
  - In TIMEOUT: done_o=1, fail_o=1, timeout_o=1, and fail_testnum_o=tnum_sh.
- MONITOR_TIMEOUT_EN undefined:
  - The TIMEOUT state and comparator are not built, and timeout_o is tied to 0.
  - RUN waits indefinitely.

## Structure
- Shared package riscv_test_monitor_pkg holds:
  - the state enum typedef;
  - default register indices (DONE_REG, PASS_REG, TNUM_REG) as localparams.
- One sub-module, wb_reg_shadow: a single address-matched shadow register, parameterised by index and width, instantiated three times.
- The FSM, settle counter and cycle counter live in the top module.

## Test plan
- Pass: write x3=5, x27=1, then x26=1 → done_o=1 and pass_o=1 exactly 10 cycles later; fail_testnum_o=5.
- Fail: write x3=7, x27=0, then x26=1 → fail_o=1 and timeout_o=0 after 10 cycles; fail_testnum_o=7.
- Late pass write: x26=1, then x27=1 on the 10th settle cycle → pass_o=1. The same write after done_o=1 leaves fail_o latched.
- Filtering: x26=2, writes to x0, and writes with wb_we_i=0 to x26 with value 1 → FSM stays RUN and done_o=0.
- Timeout (macro defined, TIMEOUT_CYCLES=50): no writes → timeout_o=1, fail_o=1, and cycle_count_o=50 at detection. Same stimulus with macro undefined → done_o stays 0 after 200 cycles.
- Reset mid-SETTLE: rst=1 for one cycle at settle cycle 4 → all outputs 0, cycle_count_o=0, and a new pass sequence completes normally.
